loader_write_scheduler: RTL and testbench

Sequences APF bridge write traffic during data-slot loading into a single downstream memory port. Each bridge write is decoded against NUM_MAPS address windows, translated to its target address, and buffered in a small FIFO. The FIFO drains through a valid/ready handshake. The block also tracks misses and overflows, and signals load completion once the FIFO has drained. It sits between the bridge endpoint in core_top and the memory writer.

---
 rtl/loader_write_scheduler.sv | 143 ++++++++++++++
 tb/tb_loader_write_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loader_write_scheduler.sv
// loader_write_scheduler: decodes APF bridge writes against address windows,
// translates them, and queues them in a small FIFO for one memory port.
module loader_write_scheduler #(
    parameter int unsigned               NUM_MAPS       = 2,
    parameter logic [NUM_MAPS-1:0][31:0] BASE_ADDRESSES = '0,
    parameter logic [NUM_MAPS-1:0][31:0] MAP_ADDRESSES  = '0,
    parameter logic [NUM_MAPS-1:0][15:0] MAP_LENGTHS    = '0,
    parameter int unsigned               FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    input  logic        load_end,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [2:0]  mem_map_index,
    output logic        busy,
    output logic        load_done,
    output logic [15:0] miss_count,
    output logic        overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t state, next_state;

    logic        hit;
    logic [2:0]  hit_index;
    logic [31:0] mapped_addr;
    logic [32:0] win_end;

    logic [31:0] fifo_addr [FIFO_DEPTH];
    logic [31:0] fifo_data [FIFO_DEPTH];
    logic [2:0]  fifo_idx  [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

    logic empty, full, enq, deq, drop, done_set;

    // Window end is formed at 33 bits so a window touching the top of the
    // address space cannot wrap and capture low addresses.
    always_comb begin
        hit         = 1'b0;
        hit_index   = '0;
        mapped_addr = '0;
        win_end     = '0;
        for (int unsigned i = 0; i < NUM_MAPS; i++) begin
            win_end = {1'b0, BASE_ADDRESSES[i]} + {17'b0, MAP_LENGTHS[i]};
            if (!hit && MAP_LENGTHS[i] != '0 &&
                bridge_addr >= BASE_ADDRESSES[i] &&
                {1'b0, bridge_addr} < win_end) begin
                hit         = 1'b1;
                hit_index   = 3'(i);
                mapped_addr = bridge_addr - BASE_ADDRESSES[i] + MAP_ADDRESSES[i];
            end
        end
    end

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign deq   = !empty && mem_ready;
    assign enq   = bridge_wr && hit && (!full || deq);
    assign drop  = bridge_wr && hit && full && !deq;

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= mapped_addr;
            fifo_data[wr_ptr] <= bridge_wr_data;
            fifo_idx[wr_ptr]  <= hit_index;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Head fields are forced to zero when empty so stale entries never leak.
    assign mem_valid     = !empty;
    assign mem_addr      = empty ? '0 : fifo_addr[rd_ptr];
    assign mem_data      = empty ? '0 : fifo_data[rd_ptr];
    assign mem_map_index = empty ? '0 : fifo_idx[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miss_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (bridge_wr && !hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enq) next_state = load_end ? DRAIN : ACTIVE;
            ACTIVE:  if (load_end) next_state = DRAIN;
            DRAIN:   if (empty && !enq) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done_set = ((state == IDLE) && load_end && !enq) ||
                   ((state == DRAIN) && empty && !enq);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) load_done <= 1'b0;
        else          load_done <= done_set;
    end

endmodule

// File: tb/tb_loader_write_scheduler.sv
// Bench for loader_write_scheduler: scoreboard of expected memory writes
// plus per-scenario tasks with inline checks.
module tb_loader_write_scheduler;

    localparam int unsigned NM    = 5;
    localparam int unsigned DEPTH = 4;
    localparam logic [NM-1:0][31:0] P_BASE = {32'h3000_0000, 32'hFFFF_FF00,
                                              32'h1FFF_FF00, 32'h2000_0000, 32'h1000_0000};
    localparam logic [NM-1:0][31:0] P_MAP  = {32'h0000_9000, 32'h0000_6000,
                                              32'h0005_0000, 32'h8000_0000, 32'h0000_4000};
    localparam logic [NM-1:0][15:0] P_LEN  = {16'h0000, 16'h0200, 16'h0200, 16'h1000, 16'h0100};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] bridge_addr = '0;
    logic        bridge_wr = 1'b0;
    logic [31:0] bridge_wr_data = '0;
    logic        load_end = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [2:0]  mem_map_index;
    logic        busy;
    logic        load_done;
    logic [15:0] miss_count;
    logic        overflow;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  i;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] miss_m = '0;
    logic        ovf_m = 1'b0;

    loader_write_scheduler #(
        .NUM_MAPS(NM),
        .BASE_ADDRESSES(P_BASE),
        .MAP_ADDRESSES(P_MAP),
        .MAP_LENGTHS(P_LEN),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bridge_addr(bridge_addr),
        .bridge_wr(bridge_wr),
        .bridge_wr_data(bridge_wr_data),
        .load_end(load_end),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_map_index(mem_map_index),
        .busy(busy),
        .load_done(load_done),
        .miss_count(miss_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every accepted head must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e, got;
        if (reset_n && mem_valid && mem_ready) begin
            total++;
            got = '{a: mem_addr, d: mem_data, i: mem_map_index};
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %h want nothing", got);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL sb_entry: got %h want %h", got, e);
                end
            end
        end
    end

    function automatic void ref_decode(input logic [31:0] a, output logic h,
                                       output logic [2:0] idx, output logic [31:0] m);
        longint unsigned lo, hi, t;
        h = 1'b0; idx = '0; m = '0;
        for (int i = 0; i < NM; i++) begin
            lo = longint'(P_BASE[i]);
            hi = lo + longint'(P_LEN[i]);
            if (!h && P_LEN[i] != 16'h0 && longint'(a) >= lo && longint'(a) < hi) begin
                h   = 1'b1;
                idx = 3'(i);
                t   = longint'(a) + longint'(P_MAP[i]) - lo;
                m   = t[31:0];
            end
        end
    endfunction

    // Drives one write cycle (entered and left at posedge+1) and updates the model.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic le);
        logic h;
        logic [2:0] idx;
        logic [31:0] m;
        ref_decode(a, h, idx, m);
        if (h) begin
            if (sb.size() < DEPTH || (mem_ready && sb.size() > 0))
                sb.push_back('{a: m, d: d, i: idx});
            else
                ovf_m = 1'b1;
        end else if (miss_m != 16'hFFFF) begin
            miss_m = miss_m + 16'd1;
        end
        bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1; load_end = le;
        @(posedge clk); #1;
        bridge_wr = 1'b0; load_end = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; bridge_wr = 1'b0; load_end = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        sb.delete(); miss_m = '0; ovf_m = 1'b0;
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", mem_valid); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        total++; if (mem_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", mem_data); end
        total++; if (mem_map_index !== 3'h0) begin bad++; $display("FAIL rst_idx: got %h want 0", mem_map_index); end
        total++; if ({busy, load_done, overflow} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {busy, load_done, overflow}); end
        total++; if (miss_count !== 16'h0) begin bad++; $display("FAIL rst_miss: got %h want 0", miss_count); end
    endtask

    task automatic test_basic();
        apply_reset();
        mem_ready = 1'b1;
        do_write(32'h1000_0010, 32'hDEAD_BEEF, 1'b0);
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", mem_valid); end
        total++; if (mem_addr !== 32'h0000_4010) begin bad++; $display("FAIL basic_addr: got %h want 00004010", mem_addr); end
        total++; if (mem_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_data: got %h want deadbeef", mem_data); end
        total++; if (mem_map_index !== 3'd0) begin bad++; $display("FAIL basic_idx: got %0d want 0", mem_map_index); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_after: got %b want 0", mem_valid); end
    endtask

    task automatic test_boundaries();
        logic [31:0] ta [6] = '{32'h0FFF_FFFC, 32'h1000_00FC, 32'h1000_0100,
                                32'h0000_0010, 32'h3000_0000, 32'hFFFF_FFF0};
        logic        tv [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] tm [6] = '{32'h0, 32'h0000_40FC, 32'h0, 32'h0, 32'h0, 32'h0000_60F0};
        apply_reset();
        mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            do_write(ta[k], 32'h5500_0000 + 32'(k), 1'b0);
            total++;
            if (mem_valid !== tv[k] || (tv[k] && mem_addr !== tm[k])) begin
                bad++;
                $display("FAIL bound_%0d: got valid=%b addr=%h want valid=%b addr=%h",
                         k, mem_valid, mem_addr, tv[k], tm[k]);
            end
        end
        @(posedge clk); #1;
        total++; if (miss_count !== 16'd4) begin bad++; $display("FAIL bound_miss: got %0d want 4", miss_count); end
        total++; if (miss_count !== miss_m) begin bad++; $display("FAIL bound_miss_model: got %0d want %0d", miss_count, miss_m); end
    endtask

    task automatic test_overlap();
        apply_reset();
        mem_ready = 1'b1;
        do_write(32'h2000_0010, 32'h1111_0001, 1'b0);
        total++; if ({mem_map_index, mem_addr} !== {3'd1, 32'h8000_0010}) begin
            bad++; $display("FAIL overlap_low: got idx=%0d addr=%h want idx=1 addr=80000010", mem_map_index, mem_addr); end
        do_write(32'h1FFF_FF10, 32'h1111_0002, 1'b0);
        total++; if ({mem_map_index, mem_addr} !== {3'd2, 32'h0005_0010}) begin
            bad++; $display("FAIL overlap_only2: got idx=%0d addr=%h want idx=2 addr=00050010", mem_map_index, mem_addr); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int n;
        apply_reset();
        mem_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            do_write(32'h1000_0000 + 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b0);
        total++; if (overflow !== 1'b1 || ovf_m !== 1'b1) begin bad++; $display("FAIL bp_overflow: got %b want 1", overflow); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({mem_valid, mem_addr, mem_data, mem_map_index} !== {1'b1, 32'h0000_4000, 32'hA000_0000, 3'd0}) begin
                bad++; $display("FAIL bp_hold_%0d: got v=%b a=%h d=%h want v=1 a=00004000 d=a0000000", k, mem_valid, mem_addr, mem_data);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_drain_timeout: got %0d left want 0", sb.size()); end
        repeat (2) @(posedge clk); #1;
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL bp_fifth: got valid=%b want 0", mem_valid); end
    endtask

    task automatic test_full_simul();
        int n;
        apply_reset();
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            do_write(32'h1000_0020 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 1'b0);
        mem_ready = 1'b1;
        do_write(32'h1000_0080, 32'hC0DE_0005, 1'b0);
        mem_ready = 1'b0;
        total++; if (overflow !== 1'b0 || ovf_m !== 1'b0) begin bad++; $display("FAIL full_ovf: got %b want 0", overflow); end
        repeat (2) @(posedge clk); #1;
        mem_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (mem_valid) n++;
            @(posedge clk); #1;
        end
        total++; if (n != 4) begin bad++; $display("FAIL full_count: got %0d entries want 4", n); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL full_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_load_end_idle();
        apply_reset();
        load_end = 1'b1;
        @(posedge clk); #1;
        load_end = 1'b0;
        total++; if ({load_done, busy} !== 2'b10) begin bad++; $display("FAIL idle_done: got done,busy=%b want 10", {load_done, busy}); end
        @(posedge clk); #1;
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL idle_done_pulse: got %b want 0", load_done); end
    endtask

    task automatic test_first_write_load_end();
        int at;
        apply_reset();
        mem_ready = 1'b0;
        do_write(32'h1000_0044, 32'h0BAD_F00D, 1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fwle_busy: got %b want 1", busy); end
        repeat (3) @(posedge clk); #1;
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL fwle_early: got %b want 0", load_done); end
        mem_ready = 1'b1;
        at = -1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (load_done && at < 0) at = i;
        end
        total++; if (at != 1) begin bad++; $display("FAIL fwle_done: got cycle %0d want 1", at); end
    endtask

    task automatic test_drain();
        int at, pulses;
        logic b2, b3, v2;
        apply_reset();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            do_write(32'h1000_0060 + 32'(4 * k), 32'hD000_0000 + 32'(k), 1'b0);
        load_end = 1'b1; @(posedge clk); #1; load_end = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({busy, load_done, mem_valid} !== 3'b101) begin
                bad++; $display("FAIL drain_hold_%0d: got busy,done,valid=%b want 101", k, {busy, load_done, mem_valid});
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        at = -1; pulses = 0; b2 = 1'bx; b3 = 1'bx; v2 = 1'bx;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (load_done) begin pulses++; if (at < 0) at = i; end
            if (i == 2) begin b2 = busy; v2 = mem_valid; end
            if (i == 3) b3 = busy;
        end
        total++; if (pulses != 1 || at != 3) begin bad++; $display("FAIL drain_done: got %0d pulses at %0d want 1 at 3", pulses, at); end
        total++; if ({b2, v2, b3} !== 3'b100) begin bad++; $display("FAIL drain_busy: got b2,v2,b3=%b want 100", {b2, v2, b3}); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL drain_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_reset_in_drain();
        int seen;
        apply_reset();
        mem_ready = 1'b0;
        do_write(32'h1000_0090, 32'hE000_0001, 1'b0);
        do_write(32'h1000_0094, 32'hE000_0002, 1'b0);
        load_end = 1'b1; @(posedge clk); #1; load_end = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rid_busy: got %b want 1", busy); end
        #2 reset_n = 1'b0;
        #1;
        total++; if ({mem_valid, busy} !== 2'b00) begin bad++; $display("FAIL rid_async: got valid,busy=%b want 00", {mem_valid, busy}); end
        sb.delete(); miss_m = '0; ovf_m = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (load_done || mem_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rid_quiet: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_miss_saturation();
        apply_reset();
        bridge_addr = 32'h0000_0010; bridge_wr_data = '0; bridge_wr = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        total++; if (miss_count !== 16'hFFFE) begin bad++; $display("FAIL miss_fffe: got %h want fffe", miss_count); end
        @(posedge clk); #1;
        total++; if (miss_count !== 16'hFFFF) begin bad++; $display("FAIL miss_ffff: got %h want ffff", miss_count); end
        repeat (5) @(posedge clk);
        #1 bridge_wr = 1'b0;
        total++; if (miss_count !== 16'hFFFF || mem_valid !== 1'b0) begin
            bad++; $display("FAIL miss_sat: got %h valid=%b want ffff valid=0", miss_count, mem_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_overlap();
        test_backpressure();
        test_full_simul();
        test_load_end_idle();
        test_first_write_load_end();
        test_drain();
        test_reset_in_drain();
        test_miss_saturation();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_final: got %0d left want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
